// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined add/subtract datapath: mode encodings,
// chunk sizing with a legality check, and signed saturation constants.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Widest result the saturation helpers can describe.
  localparam int SAT_MAX_WIDTH = 256;

  // Bits handled per pipeline stage; returns 0 for an illegal width/stage mix
  // so the instantiating module can refuse to elaborate.
  function automatic int chunk_width(input int width, input int stages);
    if ((stages < 1) || (stages > width) || ((width % stages) != 0)) begin
      return 0;
    end
    return width / stages;
  endfunction

  // Most positive signed value of the given width: 0111..1.
  function automatic logic [SAT_MAX_WIDTH-1:0] SAT_MAX(input int width);
    logic [SAT_MAX_WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) begin
      v[i] = 1'b1;
    end
    return v;
  endfunction

  // Most negative signed value of the given width: 1000..0.
  function automatic logic [SAT_MAX_WIDTH-1:0] SAT_MIN(input int width);
    logic [SAT_MAX_WIDTH-1:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/addsub_stage.sv
// Combinational CHUNK-bit ripple adder built from full_adder cells. Besides the
// chunk sum and carry-out it exposes the carry into its top bit, which the top
// level needs on the last chunk to detect signed overflow.
module addsub_stage #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[CHUNK];
  assign cmsb = carry[CHUNK-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used as the building block of every ripple chunk.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit add/subtract unit. The operands are split into STAGES
// equal chunks; stage k ripples chunk k and registers its carry forward along
// with the untouched operand chunks and the finished lower sum chunks. The
// whole pipe advances together whenever the output register is free or being
// drained, giving one result per cycle and STAGES cycles of latency.
// Optional build macro ADDSUB_SATURATE_EN clamps overflowing results to the
// signed extremes in the final stage; ovf and cout still report the raw result.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import addsub_pkg::*;

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (CHUNK == 0) begin : g_bad_params
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES with 1 <= STAGES <= WIDTH");
  end

  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Pipeline registers, one slot per stage; slot STAGES-1 is the output.
  logic [STAGES-1:0]            v_q;
  logic [STAGES-1:0]            c_q;
  logic [STAGES-1:0][WIDTH-1:0] a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_q;
  logic                         ovf_q;

  // What each stage sees at its input and what it would register next.
  logic [STAGES-1:0]            v_in;
  logic [STAGES-1:0]            c_in;
  logic [STAGES-1:0][WIDTH-1:0] a_in;
  logic [STAGES-1:0][WIDTH-1:0] b_in;
  logic [STAGES-1:0][WIDTH-1:0] s_in;
  logic [STAGES-1:0][WIDTH-1:0] s_nx;
  logic [STAGES-1:0][CHUNK-1:0] ch_sum;
  logic [STAGES-1:0]            ch_cout;
  logic [STAGES-1:0]            ch_cmsb;

  logic             ovf_nx;
  logic [WIDTH-1:0] sum_fin;
  logic             unused_ok;

  // A single enable moves every stage at once; only a stalled, full output
  // register can hold the pipe, so in_ready never looks at in_valid.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Subtraction is a + ~b + 1, so invert b and force the initial carry.
  assign b_eff = (sub == MODE_SUB) ? ~b : b;
  assign c0    = (sub == MODE_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign v_in[k] = in_valid;
      assign a_in[k] = a;
      assign b_in[k] = b_eff;
      assign c_in[k] = c0;
      assign s_in[k] = '0;
    end else begin : g_next
      assign v_in[k] = v_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign s_in[k] = s_q[k-1];
    end

    addsub_stage #(
      .CHUNK (CHUNK)
    ) u_stage (
      .a    (a_in[k][k*CHUNK +: CHUNK]),
      .b    (b_in[k][k*CHUNK +: CHUNK]),
      .cin  (c_in[k]),
      .sum  (ch_sum[k]),
      .cout (ch_cout[k]),
      .cmsb (ch_cmsb[k])
    );

    // Lower chunks arrive already finished and upper ones are still zero,
    // so merging this stage's chunk is a plain OR.
    assign s_nx[k] = s_in[k] | (WIDTH'(ch_sum[k]) << (k * CHUNK));
  end

  assign ovf_nx = ch_cout[STAGES-1] ^ ch_cmsb[STAGES-1];

`ifdef ADDSUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(SAT_MAX(WIDTH));
  localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(SAT_MIN(WIDTH));

  // Clamp an overflowing result; a carry out of the MSB marks a negative
  // overflow, no carry out marks a positive one.
  always_comb begin
    sum_fin = s_nx[STAGES-1];
    if (ovf_nx) begin
      sum_fin = ch_cout[STAGES-1] ? SAT_LO : SAT_HI;
    end
  end
`else
  assign sum_fin = s_nx[STAGES-1];
`endif

  // Advance every stage together; reset flushes all in-flight beats and
  // clears the visible result so no partial value can appear.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      v_q            <= v_in;
      c_q            <= ch_cout;
      a_q            <= a_in;
      b_q            <= b_in;
      s_q            <= s_nx;
      s_q[STAGES-1]  <= sum_fin;
      ovf_q          <= ovf_nx;
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  // Operand copies in the output slot and carries into the MSB of inner
  // chunks have no consumer; they are collected here and left for trimming.
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1], ch_cmsb};

endmodule
